// File: rtl/union_random_generator_pkg.sv
// rtl/union_random_generator_pkg.sv - default geometry and tap-array type for the union LFSR generator
package union_random_generator_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LFSR_NUM = 2;

  typedef logic [DEFAULT_LFSR_NUM-1:0][31:0] tap_array_t;

  localparam tap_array_t DEFAULT_MASK = {32'd3, 32'd4};

endpackage

// File: rtl/union_random_generator_lfsr_cell.sv
// rtl/union_random_generator_lfsr_cell.sv - one Fibonacci LFSR with seed load, zero guard and step enable
module lfsr_cell #(
  parameter int width_p = 8,
  parameter int tap_p   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [width_p-1:0] seed,
  output logic [width_p-1:0] state,
  output logic [width_p-1:0] next
);

  assign next = {state[width_p-2:0], state[width_p-1] ^ state[tap_p]};

  // An all-zero state never leaves zero, so a zero seed is replaced by all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? '1 : seed;
    end else if (en) begin
      state <= next;
    end
  end

endmodule

// File: rtl/union_random_generator.sv
// rtl/union_random_generator.sv - 2*lfsr_num parallel LFSRs XOR-combined into one registered random word
module union_random_generator
  import union_random_generator_pkg::*;
#(
  parameter int width_p  = DEFAULT_WIDTH,
  parameter int lfsr_num = DEFAULT_LFSR_NUM,
  parameter logic [lfsr_num-1:0][31:0] mask_p = DEFAULT_MASK
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [2*lfsr_num-1:0][width_p-1:0]  seed_i,
  input  logic                                v_i,
  output logic [width_p-1:0]                  random_o,
  output logic                                v_o
);

  localparam int N = 2 * lfsr_num;

  logic                        loaded;
  logic [N-1:0][width_p-1:0]   state;
  logic [N-1:0][width_p-1:0]   next;
  logic [width_p-1:0]          mix;

  if (lfsr_num < 1 || width_p < 2) begin : g_bad_geometry
    $error("union_random_generator: lfsr_num must be >= 1 and width_p >= 2");
  end

  for (genvar k = 0; k < lfsr_num; k++) begin : g_tap_check
    if (mask_p[k] >= 32'(width_p - 1)) begin : g_bad_tap
      $error("union_random_generator: tap index out of range");
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lfsr
    lfsr_cell #(
      .width_p (width_p),
      .tap_p   (int'(mask_p[j % lfsr_num]))
    ) u_cell (
      .clk   (clk_i),
      .rst_n (reset_i),
      .load  (!loaded),
      .en    (loaded && v_i),
      .seed  (seed_i[j]),
      .state (state[j]),
      .next  (next[j])
    );

    a_no_lockup: assert property (@(posedge clk_i) disable iff (!reset_i)
      loaded |-> (state[j] != '0));
  end

  always_comb begin
    mix = '0;
    for (int j = 0; j < N; j++) begin
      mix = mix ^ next[j];
    end
  end

  // The first edge after reset only loads seeds; requests are honoured from the next edge on.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      loaded   <= 1'b0;
      random_o <= '0;
      v_o      <= 1'b0;
    end else if (!loaded) begin
      loaded <= 1'b1;
      v_o    <= 1'b0;
    end else begin
      v_o <= v_i;
      if (v_i) begin
        random_o <= mix;
      end
    end
  end

endmodule

// File: tb/tb_union_random_generator.sv
// tb/tb_union_random_generator.sv - directed and model-checked bench for union_random_generator
module tb_union_random_generator;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [3:0][7:0]  seed_i;
  logic             v_i;
  logic [7:0]       random_o;
  logic             v_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_state [4];
  int         m_tap   [4] = '{4, 3, 4, 3};

  union_random_generator dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .seed_i   (seed_i),
    .v_i      (v_i),
    .random_o (random_o),
    .v_o      (v_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_load;
    for (int j = 0; j < 4; j++) m_state[j] = (seed_i[j] == 8'd0) ? 8'hFF : seed_i[j];
  endtask

  task automatic m_req(output logic [7:0] word);
    logic fb;
    word = 8'd0;
    for (int j = 0; j < 4; j++) begin
      fb = m_state[j][7] ^ m_state[j][m_tap[j]];
      m_state[j] = (m_state[j] << 1) | {7'd0, fb};
      word = word ^ m_state[j];
    end
  endtask

  task automatic restart(input int cycles);
    reset_i = 1'b0;
    repeat (cycles) tick;
    reset_i = 1'b1;
    tick;
  endtask

  logic [7:0] exp_word;
  logic [7:0] held;
  int         reqs;
  int         budget;

  initial begin
    seed_i  = {8'd97, 8'd17, 8'd75, 8'd33};
    v_i     = 1'b0;
    reset_i = 1'b0;
    repeat (5) tick;
    check("reset_random", random_o, 0);
    check("reset_v", v_o, 0);

    v_i     = 1'b1;
    reset_i = 1'b1;
    tick;
    check("load_edge_v", v_o, 0);
    check("load_edge_random", random_o, 0);
    m_load;
    tick; m_req(exp_word);
    check("word1_v", v_o, 1);
    check("word1", random_o, 8'd52);
    tick; m_req(exp_word);
    check("word2", random_o, 8'd104);
    tick; m_req(exp_word);
    check("word3", random_o, 8'd209);
    for (int i = 4; i <= 10; i++) begin
      tick; m_req(exp_word);
      check("word_seq", random_o, exp_word);
      check("word_seq_v", v_o, 1);
    end

    restart(2);
    tick;
    check("restart_word1", random_o, 8'd52);
    tick;
    check("restart_word2", random_o, 8'd104);

    #3 reset_i = 1'b0;
    #1;
    check("async_reset_random", random_o, 0);
    check("async_reset_v", v_o, 0);
    tick;
    reset_i = 1'b1;
    tick;
    tick;
    check("toggle_word1", random_o, 8'd52);
    v_i = 1'b0;
    tick;
    check("toggle_idle_v", v_o, 0);
    check("toggle_hold", random_o, 8'd52);
    v_i = 1'b1;
    tick;
    check("toggle_word2_v", v_o, 1);
    check("toggle_word2", random_o, 8'd104);

    seed_i[0] = 8'd0;
    restart(2);
    m_load;
    tick; m_req(exp_word);
    check("zero_seed_word1", random_o, 8'h88);
    for (int i = 0; i < 20; i++) begin
      tick; m_req(exp_word);
      check("zero_seed_seq", random_o, exp_word);
    end

    for (int j = 0; j < 4; j++) seed_i[j] = 8'($urandom_range(0, 255));
    v_i = 1'b0;
    restart(2);
    m_load;
    seed_i = {8'd1, 8'd2, 8'd3, 8'd4};
    held   = 8'd0;
    reqs   = 0;
    budget = 0;
    while (reqs < 1000 && budget < 5000) begin
      v_i = ($urandom_range(0, 3) != 0);
      tick;
      budget++;
      if (v_i) begin
        m_req(exp_word);
        held = exp_word;
        reqs++;
      end
      check("rand_v", v_o, v_i);
      check("rand_word", random_o, held);
    end
    check("rand_request_budget", reqs, 1000);
    for (int j = 0; j < 4; j++) check("rand_state_nonzero", dut.state[j] != 8'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
